uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with an integrated first-word-fall-through receive FIFO and sticky error reporting. It is the next-generation receive path for the APB UART controller. Data width, parity mode, baud divider and FIFO depth are generics instead of fixed 8-bit/odd-parity/single-byte. It sits between the RX pad and the controller's register file, which pops bytes and reads and clears the error flags.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: pclk frequency in Hz.
- BAUD, 9600: line rate; DIV = CLK_FREQ/BAUD, integer division, must be ≥ 8.
- DATA_BITS, 8: payload bits per frame, 5..9.
- PARITY_MODE, 1: 0 = none, 1 = odd, 2 = even.
- FIFO_DEPTH, 8: entries; power of two, ≥ 2.

Ports:
- pclk  in  1  system clock; all logic on rising edge.
- preset  in  1  reset, asynchronous and active-high.
- rx  in  1  serial input, asynchronous; idles high.
- rd_en  in  1  pop request for the FIFO head.
- rd_data  out  DATA_BITS  FIFO head.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- err_clr  in  1  clears all sticky error flags.
- frame_err  out  1  sticky: stop bit sampled 0.
- parity_err  out  1  sticky: parity mismatch.
- overrun  out  1  sticky: good frame dropped because the FIFO was full.

## Operation
- rx passes through a 2-flop synchroniser, preset to 1. All sampling uses the synchronised value rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: a falling edge on rxs loads the bit counter with DIV/2−1 and goes to START.
- START: mid-bit sample. If 0, go to DATA. If 1, treat as a false start and return to IDLE with no flags set.
- DATA: samples are DIV cycles apart, LSB first, DATA_BITS samples. Then go to PARITY, or go to STOP when PARITY_MODE = 0.
- PARITY: odd mode requires XOR(data, p) = 1; even mode requires it to be 0.
- STOP: one sample.
  - Stop = 0: set frame_err, discard the frame, go to BREAK.
  - Stop = 1 with parity bad: set parity_err, discard the frame.
  - Stop = 1 with parity good: push the frame.
  - Either stop = 1 case returns to IDLE.
- BREAK: wait until rxs = 1, then go to IDLE. A held-low line yields exactly one frame_err.
- Push when full: drop the frame and set overrun. Exception: a push and a pop in the same cycle both succeed and level is unchanged.
- rd_en while empty is ignored. Pointers wrap modulo FIFO_DEPTH.
- Error flags: a set and err_clr in the same cycle leave the flag set (set wins).
- Reset mid-frame: everything returns to reset values immediately and the partial frame is lost.

Reset values:
- empty = 1, full = 0, level = 0.
- rd_data = 0.
- all error flags = 0.
- FSM in IDLE.

## Timing
- Synchroniser latency: 2 cycles. Start-edge detection happens 3 pclk after the rx fall.
- Sample points fall at DIV/2 + k·DIV cycles after edge detection. k = 0 is the start bit.
- Push: the cycle after the stop-bit sample.
  - empty falls and rd_data shows the byte on the next pclk edge.
- Pop: rd_en sampled high at a pclk edge. The next entry appears and level decrements on that same edge.
- full = (level == FIFO_DEPTH). empty = (level == 0). Both are registered with level.
- Flag latency: error flags assert on the edge following the stop-bit sample.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - every sample point takes rxs at mid−1, mid and mid+1 cycles and uses the 2-of-3 majority;
  - start-bit validation uses the majority as well.
- Undefined: single sample at mid-bit only.
- Frame timing and flag latency are identical in both builds.

## Test plan
All scenarios use CLK_FREQ=1_600_000, BAUD=100_000, giving DIV=16, with the other parameters at default. Bit periods are 16 pclk.
- Good frame: send 0x55 with odd parity bit 1, stop 1 -> rd_data=0x55, level=1, all errors 0. Then pulse rd_en -> empty=1.
- Frame error: send 0xA3 with stop 0, line held low for 40 bits, then high -> frame_err=1 exactly once, level=0. A following good 0x3C is received. err_clr -> frame_err=0.
- Parity error: send 0x55 with parity bit 0 -> parity_err=1, level unchanged, frame discarded.
- Overrun and ordering:
  - send 0x01..0x08 -> full=1, level=8;
  - send 0x09 -> overrun=1;
  - 8 pops return 0x01..0x08 in order, then empty=1.
- Simultaneous push and pop: with the FIFO full, assert rd_en on the push cycle -> level stays 8, overrun stays 0, tail holds the new byte.
- Glitch rejection:
  - rx low for 4 pclk -> no frame, no flags.
  - With UART_RX_MAJORITY_EN, a 1-pclk high glitch at mid-bit of data bit 0 of 0x54 -> 0x54 received.
  - Without UART_RX_MAJORITY_EN, the same stimulus -> 0x55 and parity_err=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with first-word-fall-through receive FIFO and sticky error flags.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit point.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 1,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                                 pclk,
    input  logic                                 preset,
    input  logic                                 rx,
    input  logic                                 rd_en,
    output logic [DATA_BITS-1:0]                 rd_data,
    output logic                                 empty,
    output logic                                 full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      level,
    input  logic                                 err_clr,
    output logic                                 frame_err,
    output logic                                 parity_err,
    output logic                                 overrun
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW  = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_M1  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(DIV - 1);
    localparam logic          PAR_ODD  = (PARITY_MODE == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [BW-1:0]          bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0]   shreg, shreg_nxt;
    logic                   par_ok, par_ok_nxt;
    logic                   push_c, perr_c, ferr_c;
    logic                   push_q, perr_q, ferr_q;

    logic                   rx_meta, rxs, rxs_d;
    logic                   sample_c;

    // Synchroniser plus a short history used for edge detection and sampling
`ifdef UART_RX_MAJORITY_EN
    logic rxs_d2;
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            rxs_d2  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
            rxs_d2  <= rxs_d;
        end
    end
    assign sample_c = (rxs_d2 & rxs_d) | (rxs_d & rxs) | (rxs_d2 & rxs);
`else
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end
    assign sample_c = rxs_d;
`endif

    // Receive FSM state register; push/error strobes land one edge after the stop sample
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b1;
            push_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            par_ok  <= par_ok_nxt;
            push_q  <= push_c;
            perr_q  <= perr_c;
            ferr_q  <= ferr_c;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_ok_nxt  = par_ok;
        push_c      = 1'b0;
        perr_c      = 1'b0;
        ferr_c      = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs && rxs_d) begin
                    cnt_nxt   = HALF_M1;
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!sample_c) begin
                        cnt_nxt     = FULL_M1;
                        bit_cnt_nxt = '0;
                        par_ok_nxt  = 1'b1;
                        state_nxt   = DATA;
                    end else begin
                        state_nxt   = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_nxt = {sample_c, shreg[DATA_BITS-1:1]};
                    cnt_nxt   = FULL_M1;
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        state_nxt = (PARITY_MODE == 0) ? STOP : PARITY;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            PARITY: begin
                if (cnt == '0) begin
                    par_ok_nxt = ((^shreg) ^ sample_c) == PAR_ODD;
                    cnt_nxt    = FULL_M1;
                    state_nxt  = STOP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (!sample_c) begin
                        ferr_c    = 1'b1;
                        state_nxt = BREAK;
                    end else begin
                        perr_c    = !par_ok;
                        push_c    = par_ok;
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            BREAK: begin
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO: rd_data is a registered copy of the head entry
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr, rd_ptr_inc;
    logic [LW-1:0]          level_nxt;
    logic [DATA_BITS-1:0]   head_nxt;
    logic                   do_pop_c, do_push_c, ovf_c;

    assign do_pop_c   = rd_en && !empty;
    assign do_push_c  = push_q && (!full || do_pop_c);
    assign ovf_c      = push_q && full && !do_pop_c;
    assign rd_ptr_inc = rd_ptr + AW'(1);
    assign level_nxt  = level + LW'(do_push_c) - LW'(do_pop_c);

    always_comb begin
        head_nxt = rd_data;
        if (do_pop_c) begin
            if (level > LW'(1))  head_nxt = mem[rd_ptr_inc];
            else if (do_push_c)  head_nxt = shreg;
        end else if (empty && do_push_c) begin
            head_nxt = shreg;
        end
    end

    always_ff @(posedge pclk) begin
        if (do_push_c) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            rd_data <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr_inc;
            level   <= level_nxt;
            empty   <= (level_nxt == '0);
            full    <= (level_nxt == LW'(FIFO_DEPTH));
            rd_data <= head_nxt;
        end
    end

    // Sticky error flags; a same-cycle set beats err_clr
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= ferr_q || (frame_err  && !err_clr);
            parity_err <= perr_q || (parity_err && !err_clr);
            overrun    <= ovf_c  || (overrun    && !err_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at DIV=16 (16 pclk per bit).
module tb_uart_rx_fifo;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full;
    logic [3:0] level;
    logic       frame_err, parity_err, overrun;

    int vectors = 0;
    int errors  = 0;

    uart_rx_fifo #(
        .CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY_MODE(1), .FIFO_DEPTH(8)
    ) dut (
        .pclk(pclk), .preset(preset), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .level(level), .err_clr(err_clr),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 pclk = ~pclk;

    // One pclk of stimulus, applied on the falling edge
    task automatic cyc(input logic rxv, input logic rdv, input logic clr);
        @(negedge pclk);
        rx = rxv; rd_en = rdv; err_clr = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0);
    endtask

    // Frame = start, 8 data LSB first, parity, stop; optional 1-cycle glitch and pop strobe
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                              input int glitch, input int pop_at);
        logic [10:0] bits;
        bits = {stp, p, d, 1'b0};
        for (int c = 0; c < 176; c++)
            cyc(bits[c/16] ^ logic'(c == glitch), logic'(c == pop_at), 1'b0);
        idle(4);
    endtask

    function automatic logic odd_p(input logic [7:0] d);
        return ~(^d);
    endfunction

    task automatic pop_once();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic clear_errs();
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        preset = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge pclk);
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        vectors++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        vectors++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
        vectors++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {frame_err, parity_err, overrun}); end
        preset = 1'b0;
        idle(4);
    endtask

    task automatic test_good_frame();
        send_frame(8'h55, 1'b1, 1'b1, -1, -1);
        vectors++; if (rd_data !== 8'h55) begin errors++; $display("FAIL good_data got %h exp 55", rd_data); end
        vectors++; if (level !== 4'd1) begin errors++; $display("FAIL good_level got %0d exp 1", level); end
        vectors++; if (empty !== 1'b0) begin errors++; $display("FAIL good_empty got %b exp 0", empty); end
        vectors++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL good_flags got %b exp 000", {frame_err, parity_err, overrun}); end
        pop_once();
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL good_pop_empty got %b exp 1", empty); end
        vectors++; if (level !== 4'd0) begin errors++; $display("FAIL good_pop_level got %0d exp 0", level); end
    endtask

    task automatic test_frame_error();
        logic [9:0] bits;
        bits = {1'b1, 8'hA3, 1'b0};
        for (int c = 0; c < 160; c++) cyc(bits[c/16], 1'b0, 1'b0);
        for (int c = 0; c < 16; c++) cyc(1'b0, 1'b0, 1'b0);
        vectors++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set got %b exp 1", frame_err); end
        vectors++; if (level !== 4'd0) begin errors++; $display("FAIL ferr_level got %0d exp 0", level); end
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clr got %b exp 0", frame_err); end
        for (int c = 0; c < 620; c++) cyc(1'b0, 1'b0, 1'b0);
        idle(8);
        vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_once got %b exp 0", frame_err); end
        vectors++; if (parity_err !== 1'b0) begin errors++; $display("FAIL ferr_no_perr got %b exp 0", parity_err); end
        send_frame(8'h3C, odd_p(8'h3C), 1'b1, -1, -1);
        vectors++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL ferr_next_data got %h exp 3c", rd_data); end
        vectors++; if (level !== 4'd1) begin errors++; $display("FAIL ferr_next_level got %0d exp 1", level); end
        pop_once();
    endtask

    task automatic test_parity_error();
        send_frame(8'h55, 1'b0, 1'b1, -1, -1);
        vectors++; if (parity_err !== 1'b1) begin errors++; $display("FAIL perr_set got %b exp 1", parity_err); end
        vectors++; if (level !== 4'd0) begin errors++; $display("FAIL perr_level got %0d exp 0", level); end
        vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL perr_ferr got %b exp 0", frame_err); end
        clear_errs();
        vectors++; if (parity_err !== 1'b0) begin errors++; $display("FAIL perr_clr got %b exp 0", parity_err); end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 8; i++) send_frame(8'(i), odd_p(8'(i)), 1'b1, -1, -1);
        vectors++; if (full !== 1'b1) begin errors++; $display("FAIL ovr_full got %b exp 1", full); end
        vectors++; if (level !== 4'd8) begin errors++; $display("FAIL ovr_level got %0d exp 8", level); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", overrun); end
        send_frame(8'h09, odd_p(8'h09), 1'b1, -1, -1);
        vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
        vectors++; if (level !== 4'd8) begin errors++; $display("FAIL ovr_level9 got %0d exp 8", level); end
        for (int i = 1; i <= 8; i++) begin
            vectors++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL ovr_order[%0d] got %h exp %h", i, rd_data, 8'(i)); end
            pop_once();
        end
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL ovr_drained got %b exp 1", empty); end
        pop_once();
        vectors++; if (level !== 4'd0) begin errors++; $display("FAIL ovr_pop_empty got %0d exp 0", level); end
        clear_errs();
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", overrun); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) send_frame(8'h10 + 8'(i), odd_p(8'h10 + 8'(i)), 1'b1, -1, -1);
        send_frame(8'h19, odd_p(8'h19), 1'b1, -1, 171);
        vectors++; if (level !== 4'd8) begin errors++; $display("FAIL pp_level got %0d exp 8", level); end
        vectors++; if (full !== 1'b1) begin errors++; $display("FAIL pp_full got %b exp 1", full); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL pp_overrun got %b exp 0", overrun); end
        for (int i = 2; i <= 9; i++) begin
            vectors++; if (rd_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL pp_order[%0d] got %h exp %h", i, rd_data, 8'h10 + 8'(i)); end
            pop_once();
        end
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL pp_drained got %b exp 1", empty); end
    endtask

    task automatic test_glitch();
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 1'b0);
        idle(200);
        vectors++; if (level !== 4'd0) begin errors++; $display("FAIL glitch_start_level got %0d exp 0", level); end
        vectors++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL glitch_start_flags got %b exp 000", {frame_err, parity_err, overrun}); end
        send_frame(8'h54, odd_p(8'h54), 1'b1, 23, -1);
`ifdef UART_RX_MAJORITY_EN
        vectors++; if (rd_data !== 8'h54) begin errors++; $display("FAIL glitch_maj_data got %h exp 54", rd_data); end
        vectors++; if (level !== 4'd1) begin errors++; $display("FAIL glitch_maj_level got %0d exp 1", level); end
        vectors++; if (parity_err !== 1'b0) begin errors++; $display("FAIL glitch_maj_perr got %b exp 0", parity_err); end
        pop_once();
`else
        vectors++; if (parity_err !== 1'b1) begin errors++; $display("FAIL glitch_single_perr got %b exp 1", parity_err); end
        vectors++; if (level !== 4'd0) begin errors++; $display("FAIL glitch_single_level got %0d exp 0", level); end
`endif
        clear_errs();
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits;
        send_frame(8'h0F, odd_p(8'h0F), 1'b1, -1, -1);
        bits = {1'b1, odd_p(8'hF0), 8'hF0, 1'b0};
        for (int c = 0; c < 90; c++) cyc(bits[c/16], 1'b0, 1'b0);
        @(negedge pclk);
        preset = 1'b1; rx = 1'b1;
        #1;
        vectors++; if (level !== 4'd0) begin errors++; $display("FAIL rst_mid_level got %0d exp 0", level); end
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty got %b exp 1", empty); end
        vectors++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h exp 00", rd_data); end
        idle(3);
        preset = 1'b0;
        idle(40);
        vectors++; if (level !== 4'd0) begin errors++; $display("FAIL rst_mid_lost got %0d exp 0", level); end
        send_frame(8'hA5, odd_p(8'hA5), 1'b1, -1, -1);
        vectors++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL rst_mid_next got %h exp a5", rd_data); end
        vectors++; if (level !== 4'd1) begin errors++; $display("FAIL rst_mid_next_level got %0d exp 1", level); end
        vectors++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags got %b exp 000", {frame_err, parity_err, overrun}); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_frame_error();
        test_parity_error();
        test_overrun();
        test_back_to_back();
        test_glitch();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
